// File: rtl/fifo_wr_pkg.sv
// Shared types and sizing helpers for the FIFO write-side burst producer.
// Imported by the skid buffer and the burst controller.
package fifo_wr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 8;

  function automatic int fifo_w(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer with registered upstream ready.
// Head word reads as zero while the buffer is empty.
module fifo_skid_buf
  import fifo_wr_pkg::*;
#(
  parameter int WIDTH = fifo_w(DEF_DATA_W)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd;
  logic             r_wr;
  logic [1:0]       r_cnt;
  logic             r_ready;

  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_cnt_nxt;

  assign w_push    = i_valid && r_ready;
  assign w_pop     = i_ready && (r_cnt != 2'd0);
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_cnt    <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      r_cnt   <= w_cnt_nxt;
      // ready tracks next occupancy so a full buffer is never overrun
      r_ready <= (w_cnt_nxt != 2'd2);
    end
  end

  assign o_ready = r_ready;
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = o_valid ? r_mem[r_rd] : '0;

endmodule

// File: rtl/fifo_wr_burst_ctrl.sv
// Async-FIFO write-side producer: packs {last, byte} words and
// writes them in bounded bursts gated by half-full and full.
module fifo_wr_burst_ctrl
  import fifo_wr_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int PKT_CNT_W = 16
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 s_last,
  input  logic                 wfull,
  input  logic                 wHalf_full,
  output logic [DATA_W:0]      data_write,
  output logic                 write_enable,
  output logic                 burst_active,
  output logic [PKT_CNT_W-1:0] pkt_count
);

  localparam int FIFO_W = fifo_w(DATA_W);
  localparam int BCW    = burst_cnt_w(MAX_BURST);

  state_t                r_state;
  logic [BCW-1:0]        r_burst_cnt;
  logic [PKT_CNT_W-1:0]  r_pkt_cnt;

  logic                  w_head_valid;
  logic [FIFO_W-1:0]     w_head;
  logic                  w_we;
  logic                  w_last;
  logic [BCW-1:0]        w_cnt_inc;

  fifo_skid_buf #(
    .WIDTH (FIFO_W)
  ) u_skid (
    .i_clk   (wclk),
    .i_rst   (wrst),
    .i_valid (s_valid),
    .i_data  ({s_last, s_data}),
    .o_ready (s_ready),
    .o_valid (w_head_valid),
    .o_data  (w_head),
    .i_ready (w_we)
  );

  // wfull is the only combinational input to the write strobe
  assign w_we      = (r_state == BURST) && w_head_valid && !wfull;
  assign w_last    = w_head[DATA_W];
  assign w_cnt_inc = r_burst_cnt + 1'b1;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_state     <= IDLE;
      r_burst_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_head_valid && !wHalf_full) begin
            r_state     <= BURST;
            r_burst_cnt <= '0;
          end
        end
        BURST: begin
          if (w_we) begin
            r_burst_cnt <= w_cnt_inc;
            if (w_last || (w_cnt_inc == BCW'(MAX_BURST))) begin
              r_state <= GAP;
            end
          end
        end
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_pkt_cnt <= '0;
    end else if (w_we && w_last) begin
      r_pkt_cnt <= r_pkt_cnt + 1'b1;
    end
  end

  assign data_write   = w_head;
  assign write_enable = w_we;
  assign burst_active = (r_state == BURST);
  assign pkt_count    = r_pkt_cnt;

endmodule

// File: tb/tb_fifo_wr_burst_ctrl.sv
// Directed bench for fifo_wr_burst_ctrl: reset, packing, bursts,
// full/half-full gating, packet-counter wrap and async reset.
module tb_fifo_wr_burst_ctrl;

  localparam int PCW = 8;

  logic           clk;
  logic           wrst;
  logic           s_valid;
  logic           s_ready;
  logic [7:0]     s_data;
  logic           s_last;
  logic           wfull;
  logic           whalf;
  logic [8:0]     dw;
  logic           we;
  logic           ba;
  logic [PCW-1:0] pkt;

  int nvec = 0;
  int nerr = 0;
  int exp_pkt = 0;
  bit abort = 0;

  logic [8:0] wq[$];
  int         runs[$];
  int         cur_run = 0;
  logic [8:0] txq[$];

  fifo_wr_burst_ctrl #(
    .DATA_W    (8),
    .MAX_BURST (16),
    .PKT_CNT_W (PCW)
  ) dut (
    .wclk         (clk),
    .wrst         (wrst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .wfull        (wfull),
    .wHalf_full   (whalf),
    .data_write   (dw),
    .write_enable (we),
    .burst_active (ba),
    .pkt_count    (pkt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // write monitor: records FIFO words and lengths of write runs
  always begin
    @(negedge clk);
    #1;
    if (we === 1'b1) begin
      wq.push_back(dw);
      cur_run++;
    end else if (cur_run != 0) begin
      runs.push_back(cur_run);
      cur_run = 0;
    end
  end

  task automatic mon_clr();
    wq.delete();
    runs.delete();
    cur_run = 0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // must be entered at a negedge; ready is stable there
  task automatic send_txq();
    bit r;
    bit ok;
    int t;
    foreach (txq[i]) begin
      s_valid = 1'b1;
      s_data  = txq[i][7:0];
      s_last  = txq[i][8];
      ok = 0;
      t  = 0;
      while (!ok && !abort && t < 200) begin
        r = s_ready;
        @(negedge clk);
        ok = r;
        t++;
      end
      if (abort) break;
      if (!ok) begin
        nvec++; nerr++;
        $display("FAIL send_timeout: byte %0d got ready=0 required 1", i);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic test_reset();
    wrst = 1'b1; s_valid = 1'b1; s_data = 8'h55; s_last = 1'b0;
    wfull = 1'b0; whalf = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    nvec++; if (s_ready !== 1'b0) begin nerr++;
      $display("FAIL rst_ready: got %b required 0", s_ready); end
    nvec++; if (we !== 1'b0) begin nerr++;
      $display("FAIL rst_we: got %b required 0", we); end
    nvec++; if (pkt !== '0) begin nerr++;
      $display("FAIL rst_pkt: got %h required 0", pkt); end
    nvec++; if (dw !== 9'h0) begin nerr++;
      $display("FAIL rst_dw: got %h required 000", dw); end
    nvec++; if (ba !== 1'b0) begin nerr++;
      $display("FAIL rst_ba: got %b required 0", ba); end
    @(negedge clk);
    wrst = 1'b0; s_valid = 1'b0;
    #1;
    nvec++; if (s_ready !== 1'b0) begin nerr++;
      $display("FAIL rel_ready0: got %b required 0", s_ready); end
    @(negedge clk);
    #1;
    nvec++; if (s_ready !== 1'b1) begin nerr++;
      $display("FAIL rel_ready1: got %b required 1", s_ready); end
    nvec++; if (we !== 1'b0) begin nerr++;
      $display("FAIL rel_we: got %b required 0", we); end
    exp_pkt = 0;
  endtask

  task automatic test_single();
    logic [8:0] e [3];
    logic [8:0] g;
    e[0] = 9'h0A1; e[1] = 9'h0A2; e[2] = 9'h1A3;
    @(negedge clk);
    mon_clr();
    txq = '{9'h0A1, 9'h0A2, 9'h1A3};
    send_txq();
    settle(8);
    exp_pkt = exp_pkt + 1;
    nvec++; if (wq.size() !== 3) begin nerr++;
      $display("FAIL single_cnt: got %0d required 3", wq.size()); end
    for (int i = 0; i < 3; i++) begin
      g = (i < wq.size()) ? wq[i] : 9'h1FF;
      nvec++; if (g !== e[i]) begin nerr++;
        $display("FAIL single_word%0d: got %h required %h", i, g, e[i]); end
    end
    nvec++; if (runs.size() !== 1 || runs[0] !== 3) begin nerr++;
      $display("FAIL single_run: got %0d runs required one of 3", runs.size()); end
    nvec++; if (pkt !== PCW'(exp_pkt)) begin nerr++;
      $display("FAIL single_pkt: got %0d required %0d", pkt, exp_pkt); end
  endtask

  task automatic test_burst40();
    logic [8:0] g;
    logic [8:0] e;
    int er [3];
    er[0] = 16; er[1] = 16; er[2] = 8;
    @(negedge clk);
    mon_clr();
    txq.delete();
    for (int i = 0; i < 40; i++) txq.push_back({(i == 39), 8'(i)});
    send_txq();
    settle(10);
    exp_pkt = exp_pkt + 1;
    nvec++; if (wq.size() !== 40) begin nerr++;
      $display("FAIL b40_cnt: got %0d required 40", wq.size()); end
    for (int i = 0; i < 40; i++) begin
      g = (i < wq.size()) ? wq[i] : 9'h1FF;
      e = {(i == 39), 8'(i)};
      nvec++; if (g !== e) begin nerr++;
        $display("FAIL b40_word%0d: got %h required %h", i, g, e); end
    end
    nvec++; if (runs.size() !== 3) begin nerr++;
      $display("FAIL b40_nruns: got %0d required 3", runs.size()); end
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (i >= runs.size() || runs[i] !== er[i]) begin nerr++;
        $display("FAIL b40_run%0d: got %0d required %0d", i,
                 (i < runs.size()) ? runs[i] : -1, er[i]); end
    end
    nvec++; if (pkt !== PCW'(exp_pkt)) begin nerr++;
      $display("FAIL b40_pkt: got %0d required %0d", pkt, exp_pkt); end
  endtask

  task automatic test_wfull();
    logic [8:0] g;
    logic [8:0] e;
    int t;
    @(negedge clk);
    mon_clr();
    txq.delete();
    for (int i = 0; i < 10; i++) txq.push_back({(i == 9), 8'(8'h50 + i)});
    fork
      send_txq();
      begin
        t = 0;
        while (wq.size() < 3 && t < 100) begin @(negedge clk); t++; end
        nvec++; if (wq.size() < 3) begin nerr++;
          $display("FAIL wf_start: got %0d writes required 3", wq.size()); end
        wfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
          #1;
          nvec++; if (we !== 1'b0 || ba !== 1'b1) begin nerr++;
            $display("FAIL wf_stall%0d: got we=%b ba=%b required we=0 ba=1",
                     k, we, ba); end
          if (k == 4) begin
            nvec++; if (s_ready !== 1'b0) begin nerr++;
              $display("FAIL wf_ready: got %b required 0", s_ready); end
          end
          @(negedge clk);
        end
        wfull = 1'b0;
        #1;
        nvec++; if (we !== 1'b1) begin nerr++;
          $display("FAIL wf_resume: got %b required 1", we); end
      end
    join
    settle(10);
    exp_pkt = exp_pkt + 1;
    nvec++; if (wq.size() !== 10) begin nerr++;
      $display("FAIL wf_cnt: got %0d required 10", wq.size()); end
    for (int i = 0; i < 10; i++) begin
      g = (i < wq.size()) ? wq[i] : 9'h1FF;
      e = {(i == 9), 8'(8'h50 + i)};
      nvec++; if (g !== e) begin nerr++;
        $display("FAIL wf_word%0d: got %h required %h", i, g, e); end
    end
    nvec++; if (pkt !== PCW'(exp_pkt)) begin nerr++;
      $display("FAIL wf_pkt: got %0d required %0d", pkt, exp_pkt); end
  endtask

  task automatic test_half();
    logic [8:0] g;
    logic [8:0] e;
    @(negedge clk);
    mon_clr();
    whalf = 1'b1;
    txq = '{9'h0C0, 9'h0C1};
    send_txq();
    for (int k = 0; k < 5; k++) begin
      #1;
      nvec++; if (we !== 1'b0 || ba !== 1'b0) begin nerr++;
        $display("FAIL hf_hold%0d: got we=%b ba=%b required 0 0", k, we, ba); end
      @(negedge clk);
    end
    txq = '{9'h0C2, 9'h0C3, 9'h0C4, 9'h1C5};
    fork
      send_txq();
      begin
        whalf = 1'b0;
        #1;
        nvec++; if (ba !== 1'b0) begin nerr++;
          $display("FAIL hf_idle: got %b required 0", ba); end
        @(negedge clk);
        whalf = 1'b1;
        #1;
        nvec++; if (ba !== 1'b1 || we !== 1'b1) begin nerr++;
          $display("FAIL hf_start: got ba=%b we=%b required 1 1", ba, we); end
      end
    join
    settle(10);
    whalf = 1'b0;
    exp_pkt = exp_pkt + 1;
    for (int i = 0; i < 6; i++) begin
      g = (i < wq.size()) ? wq[i] : 9'h1FF;
      e = {(i == 5), 8'(8'hC0 + i)};
      nvec++; if (g !== e) begin nerr++;
        $display("FAIL hf_word%0d: got %h required %h", i, g, e); end
    end
    nvec++; if (runs.size() !== 1 || runs[0] !== 6) begin nerr++;
      $display("FAIL hf_run: got %0d runs required one of 6", runs.size()); end
    nvec++; if (pkt !== PCW'(exp_pkt)) begin nerr++;
      $display("FAIL hf_pkt: got %0d required %0d", pkt, exp_pkt); end
  endtask

  task automatic test_wrap_reset();
    int n;
    int t;
    int sz;
    @(negedge clk);
    mon_clr();
    n = (1 << PCW) - 1 - exp_pkt;
    txq.delete();
    for (int i = 0; i < n; i++) txq.push_back({1'b1, 8'(i)});
    send_txq();
    settle(10);
    nvec++; if (wq.size() !== n) begin nerr++;
      $display("FAIL wrap_cnt: got %0d required %0d", wq.size(), n); end
    nvec++; if (pkt !== {PCW{1'b1}}) begin nerr++;
      $display("FAIL wrap_max: got %h required %h", pkt, {PCW{1'b1}}); end
    @(negedge clk);
    txq = '{9'h1EE};
    send_txq();
    settle(8);
    exp_pkt = 0;
    nvec++; if (pkt !== '0) begin nerr++;
      $display("FAIL wrap_zero: got %h required 0", pkt); end
    @(negedge clk);
    mon_clr();
    abort = 0;
    txq.delete();
    txq.push_back(9'h177);
    for (int i = 0; i < 10; i++) txq.push_back({(i == 9), 8'(8'h60 + i)});
    fork
      send_txq();
      begin
        t = 0;
        while (wq.size() < 4 && t < 100) begin @(negedge clk); t++; end
        #1;
        nvec++; if (pkt !== 1 || ba !== 1'b1) begin nerr++;
          $display("FAIL ar_pre: got pkt=%0d ba=%b required 1 1", pkt, ba); end
        #2;
        wrst  = 1'b1;
        abort = 1;
        sz = wq.size();
        #1;
        nvec++; if (we !== 1'b0 || s_ready !== 1'b0) begin nerr++;
          $display("FAIL ar_ctl: got we=%b rdy=%b required 0 0", we, s_ready); end
        nvec++; if (dw !== 9'h0 || ba !== 1'b0 || pkt !== '0) begin nerr++;
          $display("FAIL ar_out: got dw=%h ba=%b pkt=%h required 0", dw, ba, pkt); end
        @(negedge clk);
        @(negedge clk);
        wrst = 1'b0;
        #1;
        nvec++; if (we !== 1'b0) begin nerr++;
          $display("FAIL ar_rel0: got %b required 0", we); end
        @(negedge clk);
        #1;
        nvec++; if (we !== 1'b0 || s_ready !== 1'b1 || dw !== 9'h0) begin nerr++;
          $display("FAIL ar_rel1: got we=%b rdy=%b dw=%h required 0 1 0",
                   we, s_ready, dw); end
      end
    join
    settle(6);
    nvec++; if (wq.size() !== sz) begin nerr++;
      $display("FAIL ar_drop: got %0d writes required %0d", wq.size(), sz); end
    abort = 0;
  endtask

  initial begin
    wrst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    wfull = 1'b0; whalf = 1'b0;
    #1;
    test_reset();
    test_single();
    test_burst40();
    test_wfull();
    test_half();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
